// File: rtl/lut_prog_pkg.sv
// Shared types and constants for the
// serially programmable 3-input LUT.
package lut_prog_pkg;

  localparam int LUT_W = 8;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/lut_prog.sv
// 3-input LUT whose truth table is reloaded
// through a serial MSB-first shadow register.
module lut_prog
  import lut_prog_pkg::*;
#(
  parameter logic [LUT_W-1:0] INIT = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  output logic             F,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic             cfg_bit,
  output logic             cfg_ready,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic [LUT_W-1:0] table_q
);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [LUT_W-1:0]   shadow_q;
  logic [LUT_W-1:0]   shadow_d;
  logic [LUT_W-1:0]   table_d;
  logic               done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      table_q  <= INIT;
      cfg_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      table_q  <= table_d;
      cfg_done <= done_d;
    end
  end

  // ~cnt_q equals LUT_W-1-cnt_q, giving MSB-first fill
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    table_d   = table_q;
    done_d    = 1'b0;
    cfg_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d  = SHIFT;
          cnt_d    = '0;
          shadow_d = '0;
        end
      end
      SHIFT: begin
        cfg_ready = 1'b1;
        if (cfg_start) begin
          cnt_d    = '0;
          shadow_d = '0;
        end else if (cfg_valid) begin
          shadow_d[~cnt_q] = cfg_bit;
          cnt_d = cnt_q + CNT_W'(1);
          if (&cnt_q) state_d = COMMIT;
        end
      end
      COMMIT: begin
        table_d = shadow_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg_busy = (state_q != IDLE);
  assign F        = table_q[{A, B, C}];

endmodule
